// File: rtl/wm8731_pkg.sv
// Constants and types shared by the WM8731 audio datapath blocks.
// A stereo frame is 32 bits wide: left sample in the upper half, right sample in the lower half.
package wm8731_pkg;

  localparam int FRAME_W          = 32;
  localparam int HALF_W           = 16;
  localparam int BCLK_DIV_DEFAULT = 4;

  typedef struct packed {
    logic [HALF_W-1:0] left;
    logic [HALF_W-1:0] right;
  } stereo_frame_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/dac_i2s_tx_bclk_gen.sv
// Bit-clock divider. b_clk toggles every BCLK_DIV clk cycles while run is high.
// rise_evt/fall_evt flag the cycle whose closing edge toggles b_clk, so that
// downstream registers can change on the same edge as b_clk.
module bclk_gen #(
  parameter int BCLK_DIV = wm8731_pkg::BCLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic b_clk,
  output logic rise_evt,
  output logic fall_evt
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       tc;

  assign tc       = run && (div_cnt == DIV_LAST);
  assign rise_evt = tc && !b_clk;
  assign fall_evt = tc && b_clk;

  // Held cleared while stopped, so entry into run always starts from count 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= 8'd0;
      b_clk   <= 1'b0;
    end else if (!run) begin
      div_cnt <= 8'd0;
      b_clk   <= 1'b0;
    end else if (tc) begin
      div_cnt <= 8'd0;
      b_clk   <= ~b_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dac_i2s_tx.sv
// Left-justified serializer for the WM8731 DAC port: one-entry holding buffer,
// 32-bit shifter and a two-state run controller driving b_clk, dac_lr_clk and dacdat.
module dac_i2s_tx #(
  parameter int BCLK_DIV = wm8731_pkg::BCLK_DIV_DEFAULT,
  parameter int FRAME_W  = wm8731_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [FRAME_W-1:0] sample_data,
  input  logic               sample_valid,
  output logic               sample_ready,
  output logic               b_clk,
  output logic               dac_lr_clk,
  output logic               dacdat,
  output logic               underrun,
  output logic               busy
);

  import wm8731_pkg::*;

  localparam logic [4:0] LR_FALL_BIT = 5'(HALF_W);

  tx_state_t          state;
  tx_state_t          state_nxt;
  logic               run;
  logic               rise_evt;
  logic               fall_evt;
  logic [4:0]         bit_cnt;
  stereo_frame_t      buf_q;
  logic               buf_full;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] load_word;
  logic               accept;
  logic               frame_load;
  logic               frame_end;

  assign run = (state == ST_RUN);

  bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .b_clk    (b_clk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Handshake: a word transfers on a clk edge where sample_valid and sample_ready
  // are both high; sample_ready is the registered empty flag of the holding buffer.
  assign sample_ready = ~buf_full;
  assign accept       = sample_valid && !buf_full;

  // bit_cnt wraps to 0 on the rise of bit 31, so the next fall closes the frame.
  assign frame_load = rise_evt && (bit_cnt == 5'd0);
  assign frame_end  = fall_evt && (bit_cnt == 5'd0);
  assign load_word  = buf_full ? buf_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end && !en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Buffer: an accept and a frame-start load can share an edge only when the
  // buffer was empty, in which case the load sees zeros and the new word stays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q    <= '0;
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_q    <= sample_data;
      buf_full <= 1'b1;
    end else if (frame_load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 5'd0;
      shreg      <= '0;
      dacdat     <= 1'b0;
      dac_lr_clk <= 1'b0;
      underrun   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy     <= run || (state_nxt == ST_RUN);
      underrun <= frame_load && !buf_full;
      if (!run) begin
        bit_cnt    <= 5'd0;
        dacdat     <= 1'b0;
        dac_lr_clk <= 1'b0;
      end else if (rise_evt) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == 5'd0) begin
          dacdat     <= load_word[FRAME_W-1];
          shreg      <= {load_word[FRAME_W-2:0], 1'b0};
          dac_lr_clk <= 1'b1;
        end else begin
          dacdat <= shreg[FRAME_W-1];
          shreg  <= {shreg[FRAME_W-2:0], 1'b0};
          if (bit_cnt == LR_FALL_BIT) dac_lr_clk <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Bench for dac_i2s_tx: frame-level scoreboard fed by the stimulus tasks and
// drained by a pin monitor that reassembles words on falling b_clk.
module tb_dac_i2s_tx;

  localparam int DIV  = 4;
  localparam int DIV2 = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        b_clk;
  logic        dac_lr_clk;
  logic        dacdat;
  logic        underrun;
  logic        busy;

  logic        en2;
  logic [31:0] sample_data2;
  logic        sample_valid2;
  logic        sample_ready2;
  logic        b_clk2;
  logic        lr2;
  logic        dacdat2;
  logic        underrun2;
  logic        busy2;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // bit 32 = frame expected to start with an underrun, bits 31:0 = frame data
  logic [32:0] exp_q[$];

  dac_i2s_tx #(.BCLK_DIV(DIV)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .b_clk        (b_clk),
    .dac_lr_clk   (dac_lr_clk),
    .dacdat       (dacdat),
    .underrun     (underrun),
    .busy         (busy)
  );

  dac_i2s_tx #(.BCLK_DIV(DIV2)) u_dut2 (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en2),
    .sample_data  (sample_data2),
    .sample_valid (sample_valid2),
    .sample_ready (sample_ready2),
    .b_clk        (b_clk2),
    .dac_lr_clk   (lr2),
    .dacdat       (dacdat2),
    .underrun     (underrun2),
    .busy         (busy2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          bit_idx = -1;
  int          frame_starts = 0;
  int          rises = 0;
  int          last_rise_cyc = -1;
  int          last_lr_cyc = -1;
  int          busy_rise_cyc = 0;
  int          last_fall_cyc = 0;
  bit          first_rise_pending = 0;
  logic        prev_b = 0, prev_lr = 0, prev_busy = 0, prev_dd = 0;
  logic        b_rise, b_fall, lr_rise;
  logic [31:0] got;
  logic [32:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      // a frame cut short by reset never completes; its expectation is dropped
      if (bit_idx >= 0 && exp_q.size() > 0) void'(exp_q.pop_front());
      bit_idx = -1;
      prev_b = 0; prev_lr = 0; prev_busy = 0; prev_dd = 0;
      last_rise_cyc = -1; last_lr_cyc = -1; first_rise_pending = 0;
    end else begin
      b_rise  = b_clk && !prev_b;
      b_fall  = !b_clk && prev_b;
      lr_rise = dac_lr_clk && !prev_lr;
      if (busy && !prev_busy) begin
        busy_rise_cyc = cyc;
        first_rise_pending = 1;
        last_rise_cyc = -1;
        last_lr_cyc = -1;
      end
      if (busy && (dacdat !== prev_dd)) check("dacdat_moves_with_bclk_rise", b_rise, 1);
      if (underrun) check("underrun_only_at_frame_start", lr_rise, 1);
      if (b_rise) begin
        rises++;
        if (first_rise_pending) begin
          check("first_bclk_delay", cyc - busy_rise_cyc, DIV);
          first_rise_pending = 0;
        end else if (last_rise_cyc >= 0) begin
          check("bclk_period", cyc - last_rise_cyc, 2 * DIV);
        end
        last_rise_cyc = cyc;
      end
      if (lr_rise) begin
        frame_starts++;
        check("lr_rise_with_bclk_rise", b_rise, 1);
        if (last_lr_cyc >= 0) check("lr_period", cyc - last_lr_cyc, 64 * DIV);
        last_lr_cyc = cyc;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("underrun_flag", underrun, exp_q[0][32]);
        bit_idx = 0;
      end
      if (b_fall && bit_idx >= 0) begin
        got[31-bit_idx] = dacdat;
        check("lr_level", dac_lr_clk, bit_idx < 16);
        bit_idx++;
        if (bit_idx == 32) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_data", got, e[31:0]);
          end
          last_fall_cyc = cyc;
          bit_idx = -1;
        end
      end
      prev_b = b_clk; prev_lr = dac_lr_clk; prev_busy = busy; prev_dd = dacdat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_word(input logic [31:0] w);
    int n = 0;
    exp_q.push_back({1'b0, w});
    @(negedge clk);
    sample_data  = w;
    sample_valid = 1'b1;
    while (!sample_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("write_ready_seen", sample_ready, 1);
    @(negedge clk);
    sample_valid = 1'b0;
    check("ready_low_after_accept", sample_ready, 0);
  endtask

  task automatic wait_starts(input int target);
    int n = 0;
    while (frame_starts < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_reached", frame_starts >= target, 1);
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rises < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bclk_rises_reached", rises >= target, 1);
  endtask

  task automatic wait_idle(output int at_cyc);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", busy, 0);
    at_cyc = cyc;
  endtask

  task automatic check_pins_idle(input string tag);
    check({tag, "_b_clk"}, b_clk, 0);
    check({tag, "_lr"}, dac_lr_clk, 0);
    check({tag, "_dacdat"}, dacdat, 0);
  endtask

  // ---------------- stimulus ----------------
  int base;
  int idle_cyc;
  int hi, ones, n;

  initial begin
    rst_n = 1'b0; en = 1'b0; sample_data = '0; sample_valid = 1'b0;
    en2 = 1'b0; sample_data2 = '0; sample_valid2 = 1'b0;
    repeat (3) @(negedge clk);
    check_pins_idle("reset");
    check("reset_underrun", underrun, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", sample_ready, 1);
    check("reset_ready2", sample_ready2, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A5A5_0F0F, en dropped at bit 10: frame completes, then idle
    base = frame_starts;
    en = 1'b1;
    write_word(32'hA5A5_0F0F);
    wait_starts(base + 1);
    wait_rises(rises + 10);
    en = 1'b0;
    wait_idle(idle_cyc);
    check("busy_fall_after_last_fall", idle_cyc - last_fall_cyc, 1);
    check_pins_idle("after_en_drop");
    repeat (5) @(negedge clk);

    // run with nothing buffered: one all-zero underrun frame
    base = frame_starts;
    exp_q.push_back({1'b1, 32'h0});
    en = 1'b1;
    wait_starts(base + 1);
    check("ready_high_on_underrun", sample_ready, 1);
    en = 1'b0;
    wait_idle(idle_cyc);
    check("ready_high_after_underrun", sample_ready, 1);
    repeat (5) @(negedge clk);

    // back-to-back words, the second written while the first shifts
    base = frame_starts;
    write_word(32'h1234_5678);
    repeat (10) @(negedge clk);
    check("buffer_held_in_idle", sample_ready, 0);
    en = 1'b1;
    wait_starts(base + 1);
    check("ready_after_load", sample_ready, 1);
    write_word(32'hDEAD_BEEF);
    wait_rises(rises + 20);
    check("ready_low_while_pending", sample_ready, 0);
    wait_starts(base + 2);
    check("ready_after_second_load", sample_ready, 1);
    en = 1'b0;
    wait_idle(idle_cyc);
    repeat (5) @(negedge clk);

    // asynchronous reset at bit 20, then clean restart with en held high
    base = frame_starts;
    write_word($urandom);
    en = 1'b1;
    wait_starts(base + 1);
    wait_rises(rises + 20);
    #2 rst_n = 1'b0;
    #1;
    check_pins_idle("async_reset");
    check("async_reset_underrun", underrun, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_ready", sample_ready, 1);
    repeat (3) @(negedge clk);
    exp_q.push_back({1'b1, 32'h0});
    base = frame_starts;
    rst_n = 1'b1;
    wait_starts(base + 1);
    write_word($urandom);
    wait_starts(base + 2);
    en = 1'b0;
    wait_idle(idle_cyc);
    repeat (5) @(negedge clk);

    // random stream with occasional skipped writes
    base = frame_starts;
    write_word($urandom);
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_starts(base + k);
      repeat ($urandom_range(0, 100)) @(negedge clk);
      if (k == 8) en = 1'b0;
      else if ($urandom_range(0, 3) == 0) exp_q.push_back({1'b1, 32'h0});
      else write_word($urandom);
    end
    wait_idle(idle_cyc);
    check_pins_idle("stream_end");

    // BCLK_DIV=2, FFFF_0000: lr high phase equals the ones phase
    @(negedge clk);
    sample_data2  = 32'hFFFF_0000;
    sample_valid2 = 1'b1;
    @(negedge clk);
    sample_valid2 = 1'b0;
    check("div2_ready_low", sample_ready2, 0);
    en2 = 1'b1;
    n = 0;
    while (!lr2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("div2_lr_rise_seen", lr2, 1);
    check("div2_bclk_with_lr", b_clk2, 1);
    check("div2_msb_at_lr_rise", dacdat2, 1);
    check("div2_no_underrun", underrun2, 0);
    hi = 0; ones = 0; n = 0;
    while (lr2 && n < 500) begin
      hi++;
      if (dacdat2) ones++;
      @(negedge clk);
      n++;
    end
    check("div2_lr_high_clks", hi, 16 * 2 * DIV2);
    check("div2_ones_clks", ones, 16 * 2 * DIV2);
    check("div2_zero_after_half", dacdat2, 0);
    en2 = 1'b0;
    n = 0;
    while (busy2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("div2_idle", busy2, 0);
    check("div2_pins_idle", {b_clk2, lr2, dacdat2}, 3'b000);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
